// File: rtl/seq_gen_serial_tx.sv
// Serial pattern transmitter: shifts a WIDTH-bit pattern out MSB-first, repeated
// repeat_cnt times back-to-back, with a one-cycle done pulse on normal completion.
module seq_gen_serial_tx #(
  parameter int unsigned       WIDTH   = 4,
  parameter logic [WIDTH-1:0]  PATTERN = 4'b1010,
  parameter int unsigned       CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_pat,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             abort,
  output logic             x_out,
  output logic             valid_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned     IdxW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] IdxTop = IdxW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StFin} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             x_q, x_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] pat_eff;

  // A load in the same cycle as start must already feed the first bit.
  assign pat_eff = load_pat ? pattern_in : pat_q;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    x_d     = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_pat) pat_d = pattern_in;
        if (start) begin
          if (repeat_cnt == '0) begin
            state_d = StFin;
            done_d  = 1'b1;
          end else begin
            state_d = StShift;
            rep_d   = repeat_cnt;
            idx_d   = IdxTop;
            x_d     = pat_eff[IdxTop];
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      StShift: begin
        // idx_q is the index of the bit currently on x_out.
        if (abort) begin
          state_d = StIdle;
          idx_d   = IdxTop;
          rep_d   = '0;
        end else if (idx_q == '0) begin
          idx_d = IdxTop;
          if (rep_q == CNT_W'(1)) begin
            state_d = StFin;
            rep_d   = '0;
            done_d  = 1'b1;
          end else begin
            rep_d   = rep_q - CNT_W'(1);
            x_d     = pat_q[IdxTop];
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end
        end else begin
          idx_d   = idx_q - IdxW'(1);
          x_d     = pat_q[idx_d];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      pat_q   <= PATTERN;
      idx_q   <= IdxTop;
      rep_q   <= '0;
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x_out     = x_q;
  assign valid_out = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_gen_serial_tx.sv
// Directed bench for seq_gen_serial_tx; outputs compared as {x_out, valid_out, busy, done}.
module tb_seq_gen_serial_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_pat = 1'b0;
  logic [3:0] pattern_in = 4'b0000;
  logic       start = 1'b0;
  logic [7:0] repeat_cnt = 8'd0;
  logic       abort = 1'b0;
  logic       x_out, valid_out, busy, done;

  int errors = 0;
  int checks = 0;

  seq_gen_serial_tx dut (
    .clk        (clk),
    .rst        (rst),
    .load_pat   (load_pat),
    .pattern_in (pattern_in),
    .start      (start),
    .repeat_cnt (repeat_cnt),
    .abort      (abort),
    .x_out      (x_out),
    .valid_out  (valid_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({x_out, valid_out, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold: got %b want 0000", {x_out, valid_out, busy, done});
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({x_out, valid_out, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release: got %b want 0000", {x_out, valid_out, busy, done});
    end
    // Unloaded run must use the reset pattern 1010.
    start = 1'b1; repeat_cnt = 8'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] exp_bits;
      exp_bits = 4'b1010;
      checks++;
      if ({x_out, valid_out, busy, done} !== {exp_bits[3-i], 3'b110}) begin
        errors++;
        $display("FAIL reset_pattern bit%0d: got %b want %b", i,
                 {x_out, valid_out, busy, done}, {exp_bits[3-i], 3'b110});
      end
      tick();
    end
    checks++;
    if ({x_out, valid_out, busy, done} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_pattern_done: got %b want 0001", {x_out, valid_out, busy, done});
    end
    tick();
  endtask

  task automatic test_default_rep2();
    logic [7:0] exp_bits;
    logic [3:0] hist;
    int         z_cnt;
    exp_bits = 8'b10101010;
    hist     = 4'b0000;
    z_cnt    = 0;
    start = 1'b1; repeat_cnt = 8'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({x_out, valid_out, busy, done} !== {exp_bits[7-i], 3'b110}) begin
        errors++;
        $display("FAIL rep2 cycle%0d: got %b want %b", i + 1,
                 {x_out, valid_out, busy, done}, {exp_bits[7-i], 3'b110});
      end
      // Overlapping 1010 Mealy detector model fed from x_out.
      hist = {hist[2:0], x_out};
      if (valid_out && hist == 4'b1010) z_cnt++;
      tick();
    end
    checks++;
    if ({x_out, valid_out, busy, done} !== 4'b0001) begin
      errors++;
      $display("FAIL rep2 cycle9: got %b want 0001", {x_out, valid_out, busy, done});
    end
    checks++;
    if (z_cnt != 3) begin
      errors++;
      $display("FAIL rep2 detector: got %0d pulses want 3", z_cnt);
    end
    tick();
    checks++;
    if ({x_out, valid_out, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL rep2 cycle10: got %b want 0000", {x_out, valid_out, busy, done});
    end
  endtask

  // mode 0: load then start; mode 1: load and start in the same cycle.
  task automatic test_load_pattern();
    for (int mode = 0; mode < 2; mode++) begin
      logic [3:0] exp_bits;
      exp_bits = 4'b1100;
      load_pat = 1'b1;
      pattern_in = (mode == 0) ? 4'b1100 : 4'b0011;
      tick();
      load_pat = 1'b0;
      pattern_in = 4'b0000;
      if (mode == 1) begin
        load_pat = 1'b1;
        pattern_in = 4'b1100;
      end
      start = 1'b1; repeat_cnt = 8'd1;
      tick();
      start = 1'b0; load_pat = 1'b0; pattern_in = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({x_out, valid_out, busy, done} !== {exp_bits[3-i], 3'b110}) begin
          errors++;
          $display("FAIL load mode%0d bit%0d: got %b want %b", mode, i,
                   {x_out, valid_out, busy, done}, {exp_bits[3-i], 3'b110});
        end
        tick();
      end
      checks++;
      if ({x_out, valid_out, busy, done} !== 4'b0001) begin
        errors++;
        $display("FAIL load mode%0d done: got %b want 0001", mode,
                 {x_out, valid_out, busy, done});
      end
      tick();
    end
  endtask

  task automatic test_zero_reps();
    start = 1'b1; repeat_cnt = 8'd0;
    tick();
    start = 1'b0;
    checks++;
    if ({x_out, valid_out, busy, done} !== 4'b0001) begin
      errors++;
      $display("FAIL zero_reps cycle1: got %b want 0001", {x_out, valid_out, busy, done});
    end
    for (int i = 2; i <= 4; i++) begin
      tick();
      checks++;
      if ({x_out, valid_out, busy, done} !== 4'b0000) begin
        errors++;
        $display("FAIL zero_reps cycle%0d: got %b want 0000", i,
                 {x_out, valid_out, busy, done});
      end
    end
  endtask

  task automatic test_abort();
    logic [5:0] exp_bits;
    logic [3:0] exp_pat;
    exp_bits = 6'b101010;
    exp_pat  = 4'b1010;
    load_pat = 1'b1; pattern_in = 4'b1010;
    tick();
    load_pat = 1'b0;
    start = 1'b1; repeat_cnt = 8'd3;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      logic [3:0] want;
      want = (c <= 6) ? {exp_bits[6-c], 3'b110} : 4'b0000;
      checks++;
      if ({x_out, valid_out, busy, done} !== want) begin
        errors++;
        $display("FAIL abort cycle%0d: got %b want %b", c, {x_out, valid_out, busy, done}, want);
      end
      // Start/load while busy must be ignored; abort is seen at the end of cycle 6.
      if (c == 4) begin
        start = 1'b1; load_pat = 1'b1; pattern_in = 4'b0000; repeat_cnt = 8'd0;
      end
      if (c == 6) abort = 1'b1;
      tick();
      start = 1'b0; load_pat = 1'b0; abort = 1'b0;
    end
    checks++;
    if ({x_out, valid_out, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL abort no_done: got %b want 0000", {x_out, valid_out, busy, done});
    end
    start = 1'b1; repeat_cnt = 8'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({x_out, valid_out, busy, done} !== {exp_pat[3-i], 3'b110}) begin
        errors++;
        $display("FAIL abort restart bit%0d: got %b want %b", i,
                 {x_out, valid_out, busy, done}, {exp_pat[3-i], 3'b110});
      end
      tick();
    end
    checks++;
    if ({x_out, valid_out, busy, done} !== 4'b0001) begin
      errors++;
      $display("FAIL abort restart done: got %b want 0001", {x_out, valid_out, busy, done});
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    logic [3:0] exp_pat;
    exp_pat = 4'b1010;
    load_pat = 1'b1; pattern_in = 4'b1100;
    tick();
    load_pat = 1'b0;
    start = 1'b1; repeat_cnt = 8'd2;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if ({x_out, valid_out, busy, done} !== 4'b0110) begin
      errors++;
      $display("FAIL midrun cycle3: got %b want 0110", {x_out, valid_out, busy, done});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({x_out, valid_out, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL midrun async_reset: got %b want 0000", {x_out, valid_out, busy, done});
    end
    tick();
    rst = 1'b1;
    tick();
    start = 1'b1; repeat_cnt = 8'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({x_out, valid_out, busy, done} !== {exp_pat[3-i], 3'b110}) begin
        errors++;
        $display("FAIL midrun restart bit%0d: got %b want %b", i,
                 {x_out, valid_out, busy, done}, {exp_pat[3-i], 3'b110});
      end
      tick();
    end
    checks++;
    if ({x_out, valid_out, busy, done} !== 4'b0001) begin
      errors++;
      $display("FAIL midrun restart done: got %b want 0001", {x_out, valid_out, busy, done});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_default_rep2();
    test_load_pattern();
    test_zero_reps();
    test_abort();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
